multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle MIPS main-control FSM; successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath muxes and enables.
//  Waits on a req/ack memory handshake, so variable-latency memory is supported.
//  Sits between the instruction register opcode field and the shared-memory multicycle datapath.
// PARAMETERS
//  OPW      6  opcode width
//  ALUOP_W  3  ALU-op width; codes: 000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt, 110 sltu, 111 lui
//  HAS_JAL  1  1: jal is decoded; 0: jal is treated as illegal
// PORTS
//  clk            in   1        rising-edge clock
//  reset_n        in   1        async active-low reset
//  opcode         in   OPW      IR[31:26]; sampled in DECODE
//  mem_ack        in   1        memory done; valid while mem_read/mem_write is high
//  pc_write       out  1        unconditional PC load
//  pc_write_cond  out  1        PC load if branch condition holds
//  branch_ne      out  1        1 = bne, 0 = beq
//  pc_src         out  2        0 ALU result, 1 ALUOut, 2 jump target
//  i_or_d         out  1        0 PC address, 1 ALUOut address
//  mem_read       out  1        memory read request
//  mem_write      out  1        memory write request
//  ir_write       out  1        IR load
//  mem_to_reg     out  1        write-back source is MDR
//  reg_dst        out  2        0 rt, 1 rd, 2 $31
//  reg_write      out  1        register-file write enable
//  alu_src_a      out  1        0 PC, 1 A
//  alu_src_b      out  2        0 B, 1 const 4, 2 imm, 3 imm<<2
//  alu_op         out  ALUOP_W  see ALUOP_W
//  illegal        out  1        one-cycle pulse for an undecoded opcode
//  state_o        out  4        current state, for debug
// BEHAVIOUR
//  Reset: state = FETCH (0). All outputs are Moore decodes of state plus mem_ack.
//   While reset_n = 0, every output except state_o is forced to 0.
//  States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7,
//   BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JAL 12.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_src=0.
//   ir_write and pc_write are asserted only in the cycle mem_ack=1; go to DECODE on that cycle.
//   Hold in FETCH otherwise.
//  DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch-target precompute). Next state by opcode:
//   000000 -> REXEC
//   lw/lbu/lhu (100011/100100/100101) and sw/sb/sh (101011/101000/101001) -> MEMADR
//   beq 000100, bne 000101 -> BRANCH
//   addi/addiu/andi/ori/slti/sltiu/lui -> IEXEC
//   j 000010 -> JUMP
//   jal 000011 -> JAL (when HAS_JAL=1)
//   Any other opcode: illegal=1 for this cycle, then FETCH.
//  MEMADR: alu_src_a=1, alu_src_b=2, alu_op=add. Loads -> MEMRD, stores -> MEMWR.
//   The opcode class is latched in DECODE.
//  MEMRD: mem_read=1, i_or_d=1; wait for mem_ack, then MEMWB.
//  MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
//  MEMWR: mem_write=1, i_or_d=1; wait for mem_ack, then FETCH.
//  REXEC: alu_src_a=1, alu_src_b=0, alu_op=010; then RWB.
//  RWB: reg_write=1, reg_dst=1; then FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_src=1, branch_ne=(op==bne); then FETCH.
//  IEXEC: alu_src_a=1, alu_src_b=2. alu_op per opcode: addi/addiu add, andi and, ori or,
//   slti slt, sltiu sltu, lui lui. Then IWB.
//  IWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
//  JUMP: pc_write=1, pc_src=2; then FETCH.
//  JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2 (writes PC+4 to $31); then FETCH.
//  Memory handshake: request outputs stay stable until mem_ack. mem_ack outside MEMRD/MEMWR/FETCH is ignored.
//  Async reset mid-access: outputs drop to 0 immediately. The pending access is abandoned and FETCH restarts.
//  Unused 4-bit state encodings go to FETCH on the next edge.
// TESTING
//  R-type with mem_ack on the 1st FETCH cycle: 4 cycles total, states 0,1,6,7; reg_write=1 and reg_dst=1 only in state 7.
//  lw with mem_ack delayed 3 cycles in FETCH and 2 in MEMRD: states 0x4,1,2,3x3,4; 10 cycles; mem_to_reg=1 in MEMWB.
//  sw: MEMWR holds mem_write=1, i_or_d=1 until mem_ack, then FETCH; reg_write is never asserted.
//  bne: BRANCH shows pc_write_cond=1, branch_ne=1, alu_op=001, pc_src=1. jal: reg_dst=2, reg_write=1, pc_src=2.
//  opcode 6'b111111: illegal pulses 1 cycle in DECODE, then FETCH. With HAS_JAL=0, jal behaves the same.
//  reset_n=0 during MEMRD wait: all outputs 0 asynchronously; after release, FETCH with mem_read=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS main-control FSM: sequences fetch/decode/execute/memory/write-back
// and waits on a req/ack memory handshake so memory latency may vary.
module multicycle_control #(
  parameter int OPW     = 6,
  parameter int ALUOP_W = 3,
  parameter bit HAS_JAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OPW-1:0]     opcode,
  input  logic               mem_ack,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
    JAL    = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ADDIU = OPW'(6'b001001);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_SLTIU = OPW'(6'b001011);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);

  localparam logic [3*OPW-1:0] LOAD_OPS  = {OPW'(6'b100101), OPW'(6'b100100), OPW'(6'b100011)};
  localparam logic [3*OPW-1:0] STORE_OPS = {OPW'(6'b101001), OPW'(6'b101000), OPW'(6'b101011)};

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(3'b111);

  state_t               state_reg;
  logic                 is_store_reg;
  logic                 is_bne_reg;
  logic [ALUOP_W-1:0]   imm_op_reg;

  logic [2:0]           load_hit;
  logic [2:0]           store_hit;
  state_t               dec_next;
  logic                 dec_store;
  logic                 dec_legal;
  logic [ALUOP_W-1:0]   dec_imm_op;

  for (genvar gi = 0; gi < 3; gi++) begin : g_memop
    assign load_hit[gi]  = (opcode == LOAD_OPS[gi*OPW +: OPW]);
    assign store_hit[gi] = (opcode == STORE_OPS[gi*OPW +: OPW]);
  end

  always_comb begin
    dec_next   = FETCH;
    dec_store  = 1'b0;
    dec_legal  = 1'b1;
    dec_imm_op = ALU_ADD;
    case (opcode)
      OP_RTYPE:          dec_next = REXEC;
      OP_BEQ, OP_BNE:    dec_next = BRANCH;
      OP_ADDI, OP_ADDIU: dec_next = IEXEC;
      OP_ANDI:  begin dec_next = IEXEC; dec_imm_op = ALU_AND;  end
      OP_ORI:   begin dec_next = IEXEC; dec_imm_op = ALU_OR;   end
      OP_SLTI:  begin dec_next = IEXEC; dec_imm_op = ALU_SLT;  end
      OP_SLTIU: begin dec_next = IEXEC; dec_imm_op = ALU_SLTU; end
      OP_LUI:   begin dec_next = IEXEC; dec_imm_op = ALU_LUI;  end
      OP_J:              dec_next = JUMP;
      OP_JAL: begin
        if (HAS_JAL) dec_next  = JAL;
        else         dec_legal = 1'b0;
      end
      default: begin
        if (|load_hit) begin
          dec_next = MEMADR;
        end else if (|store_hit) begin
          dec_next  = MEMADR;
          dec_store = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
    endcase
  end

  // Opcode class is captured in DECODE so later states do not depend on the IR staying put.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= FETCH;
      is_store_reg <= 1'b0;
      is_bne_reg   <= 1'b0;
      imm_op_reg   <= ALU_ADD;
    end else begin
      case (state_reg)
        FETCH:  if (mem_ack) state_reg <= DECODE;
        DECODE: begin
          state_reg    <= dec_next;
          is_store_reg <= dec_store;
          is_bne_reg   <= (opcode == OP_BNE);
          imm_op_reg   <= dec_imm_op;
        end
        MEMADR: state_reg <= is_store_reg ? MEMWR : MEMRD;
        MEMRD:  if (mem_ack) state_reg <= MEMWB;
        MEMWR:  if (mem_ack) state_reg <= FETCH;
        REXEC:  state_reg <= RWB;
        IEXEC:  state_reg <= IWB;
        default: state_reg <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    illegal       = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        illegal   = ~dec_legal;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        branch_ne     = is_bne_reg;
      end
      IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = imm_op_reg;
      end
      IWB: reg_write = 1'b1;
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
      JAL: begin
        pc_write  = 1'b1;
        pc_src    = 2'd2;
        reg_write = 1'b1;
        reg_dst   = 2'd2;
      end
      default: ;
    endcase
    // Outputs must fall the instant reset asserts, not at the next edge.
    if (!reset_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = 2'd0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 2'd0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      alu_op        = ALU_ADD;
      illegal       = 1'b0;
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues hand-derived control words
// per cycle, a monitor pops and compares them against two instances (with and without jal).
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, bne;
    logic [1:0] pcsrc;
    logic       iord, mrd, mwr, irw, m2r;
    logic [1:0] rdst;
    logic       rw, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    ctl_t a;
    ctl_t b;
  } exp_t;

  localparam logic [3:0] S_F = 4'd0, S_DEC = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                         S_MW = 4'd5, S_RX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_IX = 4'd9,
                         S_IWB = 4'd10, S_J = 4'd11, S_JAL = 4'd12;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ack = 1'b0;
  ctl_t       act_a, act_b;
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_control #(.OPW(6), .ALUOP_W(3), .HAS_JAL(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ack(mem_ack),
    .pc_write(act_a.pcw), .pc_write_cond(act_a.pcwc), .branch_ne(act_a.bne),
    .pc_src(act_a.pcsrc), .i_or_d(act_a.iord), .mem_read(act_a.mrd),
    .mem_write(act_a.mwr), .ir_write(act_a.irw), .mem_to_reg(act_a.m2r),
    .reg_dst(act_a.rdst), .reg_write(act_a.rw), .alu_src_a(act_a.asa),
    .alu_src_b(act_a.asb), .alu_op(act_a.aop), .illegal(act_a.ill), .state_o(act_a.st)
  );

  multicycle_control #(.OPW(6), .ALUOP_W(3), .HAS_JAL(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ack(mem_ack),
    .pc_write(act_b.pcw), .pc_write_cond(act_b.pcwc), .branch_ne(act_b.bne),
    .pc_src(act_b.pcsrc), .i_or_d(act_b.iord), .mem_read(act_b.mrd),
    .mem_write(act_b.mwr), .ir_write(act_b.irw), .mem_to_reg(act_b.m2r),
    .reg_dst(act_b.rdst), .reg_write(act_b.rw), .alu_src_a(act_b.asa),
    .alu_src_b(act_b.asb), .alu_op(act_b.aop), .illegal(act_b.ill), .state_o(act_b.st)
  );

  // Control word each state must present; aux is the IEXEC alu_op or, in BRANCH, branch_ne.
  function automatic ctl_t ctl(input logic [3:0] st, input logic ack,
                               input logic [2:0] aux, input logic ill);
    ctl_t c;
    c = '0;
    c.st = st;
    case (st)
      S_F:   begin c.mrd = 1'b1; c.asb = 2'd1; c.irw = ack; c.pcw = ack; end
      S_DEC: begin c.asb = 2'd3; c.ill = ill; end
      S_MA:  begin c.asa = 1'b1; c.asb = 2'd2; end
      S_MR:  begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MWB: begin c.rw = 1'b1; c.m2r = 1'b1; end
      S_MW:  begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_RX:  begin c.asa = 1'b1; c.aop = 3'b010; end
      S_RWB: begin c.rw = 1'b1; c.rdst = 2'd1; end
      S_BR:  begin c.asa = 1'b1; c.aop = 3'b001; c.pcwc = 1'b1; c.pcsrc = 2'd1; c.bne = aux[0]; end
      S_IX:  begin c.asa = 1'b1; c.asb = 2'd2; c.aop = aux; end
      S_IWB: c.rw = 1'b1;
      S_J:   begin c.pcw = 1'b1; c.pcsrc = 2'd2; end
      S_JAL: begin c.pcw = 1'b1; c.pcsrc = 2'd2; c.rw = 1'b1; c.rdst = 2'd2; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic step2(input logic ack, input logic [3:0] sa, input logic ia,
                       input logic [3:0] sb, input logic ib, input logic [2:0] aux);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mem_ack = ack;
    e.a = ctl(sa, ack, aux, ia);
    e.b = ctl(sb, ack, aux, ib);
    q.push_back(e);
  endtask

  task automatic step(input logic ack, input logic [3:0] st, input logic [2:0] aux);
    step2(ack, st, 1'b0, st, 1'b0, aux);
  endtask

  task automatic rst_step();
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    mem_ack = 1'b0;
    e = '0;
    q.push_back(e);
  endtask

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dut_a", act_a, e.a);
        check("dut_b", act_b, e.b);
        $display("cyc=%0d op=%b ack=%b state_a=%0d state_b=%0d", cyc, opcode, mem_ack, act_a.st, act_b.st);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    ctl_t zero;
    zero = '0;
    rst_step();
    rst_step();

    // R-type, ack on first fetch cycle; stray ack in REXEC is ignored
    opcode = 6'b000000;
    step(1, S_F, 0); step(0, S_DEC, 0); step(1, S_RX, 0); step(0, S_RWB, 0);

    // lw: fetch waits 3 cycles, MEMRD waits 2
    opcode = 6'b100011;
    step(0, S_F, 0); step(0, S_F, 0); step(0, S_F, 0); step(1, S_F, 0);
    step(0, S_DEC, 0); step(0, S_MA, 0);
    step(0, S_MR, 0); step(0, S_MR, 0); step(1, S_MR, 0); step(0, S_MWB, 0);

    // sw with a 2-cycle write wait
    opcode = 6'b101011;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_MA, 0);
    step(0, S_MW, 0); step(0, S_MW, 0); step(1, S_MW, 0);

    // lhu and sb take the same memory paths
    opcode = 6'b100101;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_MA, 0); step(1, S_MR, 0); step(0, S_MWB, 0);
    opcode = 6'b101000;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_MA, 0); step(1, S_MW, 0);

    // bne then beq
    opcode = 6'b000101;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_BR, 3'b001);
    opcode = 6'b000100;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_BR, 3'b000);

    // immediates: ori, slti, lui, addiu
    opcode = 6'b001101;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_IX, 3'b100); step(0, S_IWB, 0);
    opcode = 6'b001010;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_IX, 3'b101); step(0, S_IWB, 0);
    opcode = 6'b001111;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_IX, 3'b111); step(0, S_IWB, 0);
    opcode = 6'b001001;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_IX, 3'b000); step(0, S_IWB, 0);

    // j
    opcode = 6'b000010;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_J, 0);

    // jal: decoded by dut_a, illegal in dut_b (which is back in FETCH a cycle early)
    opcode = 6'b000011;
    step(1, S_F, 0);
    step2(0, S_DEC, 1'b0, S_DEC, 1'b1, 0);
    step2(0, S_JAL, 1'b0, S_F, 1'b0, 0);

    // undecoded opcode
    opcode = 6'b111111;
    step(0, S_F, 0); step(1, S_F, 0);
    step2(0, S_DEC, 1'b1, S_DEC, 1'b1, 0);
    step(0, S_F, 0);

    // reset asserted mid-cycle while waiting in MEMRD
    opcode = 6'b100011;
    step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_MA, 0); step(0, S_MR, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_a", act_a, zero);
    check("async_rst_b", act_b, zero);
    rst_step();
    step(0, S_F, 0); step(1, S_F, 0); step(0, S_DEC, 0); step(0, S_MA, 0);
    step(1, S_MR, 0); step(0, S_MWB, 0);
    step(0, S_F, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain cyc=%0d got=%0d_pending want=0_pending", cyc, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
